// File: rtl/datapath_pkg.sv
// Shared constants and ALU opcodes for the regfile/ALU datapath slice.
package datapath_pkg;
  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;
endpackage

// File: rtl/regfile.sv
// 32x32 register file, R0 hardwired to zero, async active-high clear.
// REGFILE_BYPASS_EN forwards pending write data onto qa/qb only.
module regfile
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rw,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [DW-1:0] qa_raw,
  output logic [DW-1:0] qb_raw
);
  logic [DW-1:0] mem_q [NREG];
  logic          wr_en;

  assign wr_en = we && (rw != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[rw] <= wd;
    end
  end

  assign qa_raw = (ra == '0) ? '0 : mem_q[ra];
  assign qb_raw = (rb == '0) ? '0 : mem_q[rb];

`ifdef REGFILE_BYPASS_EN
  // ALU reads qa_raw/qb_raw, so forwarding wd here cannot form a loop.
  assign qa = (wr_en && (ra == rw)) ? wd : qa_raw;
  assign qb = (wr_en && (rb == rw)) ? wd : qb_raw;
`else
  assign qa = qa_raw;
  assign qb = qb_raw;
`endif
endmodule

// File: rtl/regfile_alu_datapath.sv
// Single-cycle regfile + ALU slice with write-back mux.
// Optional write-through bypass via REGFILE_BYPASS_EN (see regfile).
module regfile_alu_datapath
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          mux3,
  input  logic [2:0]    aluc,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rw,
  input  logic [DW-1:0] rd,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [DW-1:0] alu_out,
  output logic          zero
);
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] wd;

  regfile u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .ra     (ra),
    .rb     (rb),
    .rw     (rw),
    .wd     (wd),
    .qa     (qa),
    .qb     (qb),
    .qa_raw (a),
    .qb_raw (b)
  );

  always_comb begin
    alu_out = '0;
    unique case (aluc)
      ALU_ADD: alu_out = a + b;
      ALU_SUB: alu_out = a - b;
      ALU_OR:  alu_out = a | b;
      ALU_AND: alu_out = a & b;
      ALU_XOR: alu_out = a ^ b;
      ALU_SLT: alu_out = {{(DW-1){1'b0}},
                          ($signed(a) < $signed(b))};
      ALU_SLL: alu_out = b << a[4:0];
      ALU_SRL: alu_out = b >> a[4:0];
      default: alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);
  assign wd   = mux3 ? alu_out : rd;
endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Directed self-checking bench for regfile_alu_datapath.
// Expected values are hand-computed; bypass build changes one check.
module tb_regfile_alu_datapath;
  import datapath_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic          mux3;
  logic [2:0]    aluc;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [AW-1:0] rw;
  logic [DW-1:0] rd;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic [DW-1:0] alu_out;
  logic          zero;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_alu_datapath dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .mux3    (mux3),
    .aluc    (aluc),
    .ra      (ra),
    .rb      (rb),
    .rw      (rw),
    .rd      (rd),
    .qa      (qa),
    .qb      (qb),
    .alu_out (alu_out),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  ops  [8];
  logic [31:0] exps [8];

  initial begin
    ops  = '{ALU_ADD, ALU_SUB, ALU_OR, ALU_AND,
             ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL};
    exps = '{32'h9, 32'hFFFF_FFFF, 32'h5, 32'h4,
             32'h1, 32'h1, 32'h50, 32'h0};

    rst = 1'b1; we = 1'b0; mux3 = 1'b0; aluc = ALU_ADD;
    ra = 5'd0; rb = 5'd0; rw = 5'd0; rd = '0;
    #2;
    chk("rst_qa", qa, 32'h0);
    chk("rst_zero", {31'h0, zero}, 32'h1);
    tick();
    rst = 1'b0;

    we = 1'b1; rw = 5'd4; rd = 32'h4;
    tick();
    rw = 5'd5; rd = 32'h5;
    tick();
    we = 1'b0; ra = 5'd4; rb = 5'd5;
    #1;
    chk("rd_qa4", qa, 32'h4);
    chk("rd_qb5", qb, 32'h5);

    for (int i = 0; i < 8; i++) begin
      aluc = ops[i];
      #1;
      chk($sformatf("alu_op%0d", i), alu_out, exps[i]);
      chk($sformatf("zero_op%0d", i), {31'h0, zero},
          {31'h0, exps[i] == 32'h0});
    end

    we = 1'b1; mux3 = 1'b1; aluc = ALU_ADD; rw = 5'd6;
    tick();
    we = 1'b0; mux3 = 1'b0; ra = 5'd6; rb = 5'd6; aluc = ALU_SUB;
    #1;
    chk("wb_r6", qa, 32'h9);
    chk("wb_sub0", alu_out, 32'h0);
    chk("wb_zero", {31'h0, zero}, 32'h1);

    we = 1'b0; rw = 5'd7; rd = 32'hDEAD_BEEF;
    tick();
    we = 1'b1; rw = 5'd0;
    tick();
    we = 1'b0; ra = 5'd7; rb = 5'd0;
    #1;
    chk("we0_r7", qa, 32'h0);
    chk("r0_read", qb, 32'h0);

    ra = 5'd4; rb = 5'd5; aluc = ALU_ADD;
    we = 1'b1; mux3 = 1'b0; rw = 5'd4; rd = 32'h44;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_pre", qa, 32'h44);
`else
    chk("same_pre", qa, 32'h4);
`endif
    chk("same_alu", alu_out, 32'h9);
    tick();
    we = 1'b0;
    #1;
    chk("same_post", qa, 32'h44);
    chk("same_alu2", alu_out, 32'h49);

    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_qa", qa, 32'h0);
    chk("mid_rst_qb", qb, 32'h0);
    chk("mid_rst_zero", {31'h0, zero}, 32'h1);
    tick();
    rst = 1'b0;
    ra = 5'd6;
    #1;
    chk("post_rst_r6", qa, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_alu_datapath.md
Name: regfile_alu_datapath

Overview:
Single-cycle datapath slice: a 32x32-bit register file with two combinational read ports and one synchronous write port, feeding a 3-bit-controlled 32-bit ALU. The write-back data is muxed between an external data word and the ALU result. It sits between the decode/control stage, which supplies register addresses and control, and the write-back path. It is the building block for the CPU pipeline's execute stage.

Parameters:
DW, 32, data width of registers, ALU operands and result
NREG, 32, number of registers; address width is log2(NREG) = 5

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  asynchronous, active-high reset
we  in  1  register-file write enable
mux3  in  1  write-back select: 0 = rd, 1 = alu_out
aluc  in  3  ALU operation code
ra  in  5  read address, port A
rb  in  5  read address, port B
rw  in  5  write address
rd  in  32  external write data
qa  out  32  register[ra], combinational
qb  out  32  register[rb], combinational
alu_out  out  32  ALU result, combinational
zero  out  1  1 when alu_out == 0

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset: while rst=1, all 32 registers clear to 0 immediately, independent of clk. Consequently qa=qb=0, alu_out is the function of (0,0) and zero reflects that result (1 for every aluc code except SLT, whose result is also 0, so zero=1 in all cases).
- Write: on each clk rising edge with rst=0 and we=1, reg[rw] <= (mux3 ? alu_out : rd). If we=0, nothing is written.
- R0: hardwired to 0. Writes to rw=0 are ignored, and reads of address 0 always return 0.
- Read: qa=reg[ra] and qb=reg[rb], purely combinational, 0-cycle latency. Without the optional feature there is no bypass: a write becomes visible after the clock edge.
- Simultaneous read/write to the same address: the read returns the old value until the edge.
- ALU, with A=qa and B=qb, combinational. All arithmetic is 32-bit modulo 2^32; no carry or overflow outputs.
  - 000 ADD: A+B
  - 001 SUB: A-B (4-5 = FFFFFFFF)
  - 010 OR: A|B
  - 011 AND: A&B
  - 100 XOR: A^B
  - 101 SLT: ($signed(A) < $signed(B)) ? 1 : 0
  - 110 SLL: B << A[4:0]
  - 111 SRL: B >> A[4:0] (logical)
- zero is asserted when alu_out == 32'h0.
- ALU write-back with mux3=1 uses the current-cycle alu_out, which depends on current ra/rb. Using rw equal to ra or rb is legal: the old value is used and the new value is stored at the edge.
- Unknown or X inputs: no requirement.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. When we=1, rw!=0 and ra==rw (resp. rb==rw), qa (resp. qb) returns the pending write data (mux3 ? alu_out : rd) in the same cycle.
- To avoid a combinational loop, a forwarded alu_out is not used for the ALU operands. The ALU operands always come from the unbypassed register contents; only the qa/qb outputs are bypassed.
- Undefined: no bypass, exactly as in Behaviour.

Decomposition:
- Package datapath_pkg: DW and NREG constants, and the aluc opcode localparams ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL.
- One natural sub-module, regfile, containing the storage, reset, R0 handling and the optional bypass.
- The ALU and the write-back mux stay in the top module.

Test Plan:
- Reset pulse mid-run after writes -> all reads return 0 immediately, before any clock edge; zero=1.
- we=1, mux3=0, rw=4, rd=04, then rw=5, rd=05 -> next cycle ra=4, rb=5 gives qa=04, qb=05.
- ra=4, rb=5 with aluc swept:
  - ADD=09, SUB=FFFFFFFF, OR=05, AND=04, XOR=01
  - SLT=1, with zero=0 for all of these
- Write-back of ALU results:
  - we=1, mux3=1, aluc=ADD, rw=6 -> R6=09
  - ra=6, rb=6, aluc=SUB -> alu_out=0, zero=1
- Writes with we=0 or rw=0 (rd=DEADBEEF) -> the target is unchanged; R0 still reads 0.
- Same-cycle read of rw=ra while writing: old value before the edge, new value after; with REGFILE_BYPASS_EN, the new value appears on qa in the same cycle.
